// File: rtl/pipe_stage_buf_if.sv
// Handshake and payload bundle for pipe_stage_buf: upstream entry in, registered entry out.
// slave is the stage's view, master is the surrounding pipeline's view.
interface pipe_stage_buf_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  ins_in;
  logic [XLEN-1:0]  pc_in;
  logic [XLEN-1:0]  alu_result_in;
  logic [XLEN-1:0]  rt_data_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  ins_m;
  logic [XLEN-1:0]  pc_m;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  rt_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, ins_in, pc_in, alu_result_in, rt_data_in, out_ready,
    output in_ready, out_valid, ins_m, pc_m, alu_result, rt_data, occupancy, stall_cnt
  );

  modport master (
    output in_valid, ins_in, pc_in, alu_result_in, rt_data_in, out_ready,
    input  in_ready, out_valid, ins_m, pc_m, alu_result, rt_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer pipeline register: main entry drives the outputs, skid catches the
// one entry that arrives while downstream stalls. in_ready is registered to break the ready path.
module pipe_stage_buf #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] NOP_INS = '0,
  parameter int              CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  pipe_stage_buf_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_e;

  // Entry fields packed as [0]=ins, [1]=pc, [2]=alu_result, [3]=rt_data.
  localparam logic [3:0][XLEN-1:0] BUBBLE = {{XLEN{1'b0}}, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP_INS};

  state_e                  state_q, state_d;
  logic [3:0][XLEN-1:0]    main_q, main_d;
  logic [3:0][XLEN-1:0]    skid_q, skid_d;
  logic                    in_ready_q, in_ready_d;
  logic [CNT_W-1:0]        stall_q, stall_d;
  logic [3:0][XLEN-1:0]    in_pl;
  logic                    out_valid, in_fire, out_fire;

  assign in_pl     = {bus.rt_data_in, bus.alu_result_in, bus.pc_in, bus.ins_in};
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = HALF;
          main_d  = in_pl;
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_d = in_pl;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_pl;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        FULL: if (out_fire) begin
          state_d = HALF;
          main_d  = skid_q;
          skid_d  = '0;
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
    // Stall counting is independent of flush; only reset clears it.
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid;
  assign bus.ins_m      = main_q[0];
  assign bus.pc_m       = main_q[1];
  assign bus.alu_result = main_q[2];
  assign bus.rt_data    = main_q[3];
  assign bus.occupancy  = state_q;
  assign bus.stall_cnt  = stall_q;
endmodule
